// File: rtl/sm3_req_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sm3_req_arb                                                  |
// | Description : Multi-requester front end for an SM3 hash core. Grants one    |
// |               requester per message, streams its beats to the core and      |
// |               returns the digest to that owner. Define SM3_ARB_RR_EN for    |
// |               round-robin arbitration (default: fixed priority, index 0).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sm3_req_arb #(
   parameter int NREQ = 2,
   parameter int DW   = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ*DW-1:0]     req_d_i,
   input  logic [NREQ*DW/8-1:0]   req_vld_byte_i,
   input  logic [NREQ-1:0]        req_vld_i,
   input  logic [NREQ-1:0]        req_lst_i,
   output logic [NREQ-1:0]        req_rdy_o,
   output logic [DW-1:0]          core_d_o,
   output logic [DW/8-1:0]        core_vld_byte_o,
   output logic                   core_vld_o,
   output logic                   core_lst_o,
   input  logic                   core_rdy_i,
   input  logic [255:0]           core_res_i,
   input  logic                   core_res_vld_i,
   output logic [255:0]           res_o,
   output logic [NREQ-1:0]        res_vld_o,
   output logic [NREQ-1:0]        gnt_o,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int         c_PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_STREAM = 2'd1;
   localparam logic [1:0] c_WAIT   = 2'd2;
   localparam logic [1:0] c_RESP   = 2'd3;

   logic [1:0]      r_state;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_res_vld;
   logic [255:0]    r_res;
   logic            r_err;

   logic            w_any;
   logic [NREQ-1:0] w_win_oh;
   logic [DW-1:0]   w_own_d;
   logic [DW/8-1:0] w_own_byte;
   logic            w_own_vld;
   logic            w_own_lst;
   logic            w_streaming;

`ifdef SM3_ARB_RR_EN
   logic [c_PW-1:0] r_ptr;
   logic [c_PW-1:0] w_ptr_nxt;
   logic [c_PW:0]   w_cand;

   // Search starts at the pointer and wraps; first valid requester wins.
   always_comb begin
      w_any    = 1'b0;
      w_win_oh = '0;
      w_cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_cand = {1'b0, r_ptr} + (c_PW+1)'(i);
         if (w_cand >= (c_PW+1)'(NREQ))
            w_cand = w_cand - (c_PW+1)'(NREQ);
         if (!w_any && req_vld_i[w_cand[c_PW-1:0]]) begin
            w_any                        = 1'b1;
            w_win_oh[w_cand[c_PW-1:0]]   = 1'b1;
         end
      end
   end

   always_comb begin
      w_ptr_nxt = '0;
      for (int k = 0; k < NREQ; k++)
         if (r_gnt[k])
            w_ptr_nxt = c_PW'((k + 1) % NREQ);
   end
`else
   // Descending scan so the lowest valid index is the last one written.
   always_comb begin
      w_any    = 1'b0;
      w_win_oh = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_vld_i[i]) begin
            w_any       = 1'b1;
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      end
   end
`endif

   // One-hot grant selects the owner's slice.
   always_comb begin
      w_own_d    = '0;
      w_own_byte = '0;
      w_own_vld  = 1'b0;
      w_own_lst  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (r_gnt[k]) begin
            w_own_d    = req_d_i[k*DW +: DW];
            w_own_byte = req_vld_byte_i[k*(DW/8) +: DW/8];
            w_own_vld  = req_vld_i[k];
            w_own_lst  = req_lst_i[k];
         end
      end
   end

   assign w_streaming     = (r_state == c_STREAM);
   assign core_d_o        = w_streaming ? w_own_d    : '0;
   assign core_vld_byte_o = w_streaming ? w_own_byte : '0;
   assign core_vld_o      = w_streaming & w_own_vld;
   assign core_lst_o      = w_streaming & w_own_lst;
   assign req_rdy_o       = w_streaming ? (r_gnt & {NREQ{core_rdy_i}}) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_IDLE;
         r_gnt     <= '0;
         r_res     <= '0;
         r_res_vld <= '0;
         r_err     <= 1'b0;
`ifdef SM3_ARB_RR_EN
         r_ptr     <= '0;
`endif
      end else begin
         r_res_vld <= '0;
         // A digest arriving before the message is complete is a protocol error.
         if (core_res_vld_i && (r_state == c_IDLE || r_state == c_STREAM))
            r_err <= 1'b1;
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_win_oh;
                  r_state <= c_STREAM;
               end
            end
            c_STREAM: begin
               if (w_own_vld && w_own_lst && core_rdy_i)
                  r_state <= c_WAIT;
            end
            c_WAIT: begin
               if (core_res_vld_i) begin
                  r_res     <= core_res_i;
                  r_res_vld <= r_gnt;
                  r_state   <= c_RESP;
               end
            end
            c_RESP: begin
               r_gnt   <= '0;
               r_state <= c_IDLE;
`ifdef SM3_ARB_RR_EN
               r_ptr   <= w_ptr_nxt;
`endif
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign gnt_o     = r_gnt;
   assign res_o     = r_res;
   assign res_vld_o = r_res_vld;
   assign busy_o    = (r_state != c_IDLE);
   assign err_o     = r_err;

endmodule
`default_nettype wire
